// File: rtl/ex_cdb_arbiter_pkg.sv
// Shared types for the execute-to-CDB complete path.
package ex_cdb_arbiter_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest_reg;
    logic        is_ZEROREG;
  } ex_packet_t;

  // Canonical "nothing here" packet, also used by FU and retire logic.
  localparam ex_packet_t EX_PACKET_EMPTY = '{
    pc: 32'd0, result: 32'd0, dest_reg: 5'd0, is_ZEROREG: 1'b1
  };

endpackage

// File: rtl/ex_cdb_arbiter_if.sv
// FU-side and CDB-side handshake bundle for the complete-stage arbiter.
interface ex_cdb_arbiter_if
  import ex_cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = $clog2(NUM_REQ)
) ();

  logic       [NUM_REQ-1:0] fu_valid;
  ex_packet_t [NUM_REQ-1:0] fu_packet;
  logic       [NUM_REQ-1:0] fu_stall;
  logic                     cdb_ready;
  logic                     cdb_valid;
  ex_packet_t               cdb_packet;
  logic       [IDX_W-1:0]   cdb_src;

  modport master (
    output fu_valid, fu_packet, cdb_ready,
    input  fu_stall, cdb_valid, cdb_packet, cdb_src
  );

  modport slave (
    input  fu_valid, fu_packet, cdb_ready,
    output fu_stall, cdb_valid, cdb_packet, cdb_src
  );

endinterface

// File: rtl/ex_cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker; search starts one past last_grant and wraps.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    if (en) begin
      for (int off = 1; off <= N; off++) begin
        // one extra bit keeps last_grant+off from overflowing before the wrap
        idx = {1'b0, last_grant} + (IW+1)'(off);
        if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
        if (!any && req[idx[IW-1:0]]) begin
          any                   = 1'b1;
          grant[idx[IW-1:0]]    = 1'b1;
          grant_idx             = idx[IW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ex_cdb_arbiter.sv
// One-entry holding slot per FU, round-robin drained into a registered CDB output.
module ex_cdb_arbiter
  import ex_cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input logic clock,
  input logic reset,
  input logic squash,
  ex_cdb_arbiter_if.slave bus
);

  ex_packet_t [NUM_REQ-1:0] slot;
  logic       [NUM_REQ-1:0] slot_full, grant, accept;
  logic       [IDX_W-1:0]   last_grant, grant_idx;
  logic                     any, advance;

  ex_packet_t               cdb_packet_q;
  logic                     cdb_valid_q;
  logic       [IDX_W-1:0]   cdb_src_q;

  assign advance = ~cdb_valid_q | bus.cdb_ready;

  // squash outranks any grant, so the picker is simply disabled that cycle
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (slot_full),
    .last_grant (last_grant),
    .en         (advance & ~squash),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (any)
  );

  assign bus.fu_stall = squash ? '0 : (slot_full & ~grant);
  assign accept       = bus.fu_valid & ~bus.fu_stall & {NUM_REQ{~squash}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_full <= '0;
      slot      <= {NUM_REQ{EX_PACKET_EMPTY}};
    end else if (squash) begin
      slot_full <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        // a granted slot may reload in the same cycle without a bubble
        if (accept[i]) begin
          slot[i]      <= bus.fu_packet[i];
          slot_full[i] <= 1'b1;
        end else if (grant[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid_q  <= 1'b0;
      cdb_packet_q <= EX_PACKET_EMPTY;
      cdb_src_q    <= '0;
      last_grant   <= IDX_W'(NUM_REQ-1);
    end else if (squash) begin
      cdb_valid_q  <= 1'b0;
      cdb_packet_q <= EX_PACKET_EMPTY;
    end else if (advance) begin
      if (any) begin
        cdb_valid_q  <= 1'b1;
        cdb_packet_q <= slot[grant_idx];
        cdb_src_q    <= grant_idx;
        last_grant   <= grant_idx;
      end else begin
        cdb_valid_q  <= 1'b0;
        cdb_packet_q <= EX_PACKET_EMPTY;
      end
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_packet = cdb_packet_q;
  assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_ex_cdb_arbiter.sv
// Directed scenario bench for ex_cdb_arbiter with hand-computed expectations.
module tb_ex_cdb_arbiter;
  import ex_cdb_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  int   checks   = 0;
  int   failures = 0;

  ex_cdb_arbiter_if #(.NUM_REQ(3)) bus ();

  ex_cdb_arbiter #(.NUM_REQ(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic ex_packet_t mk(input logic [31:0] pc);
    ex_packet_t p;
    p.pc         = pc;
    p.result     = pc ^ 32'hA5A5_0000;
    p.dest_reg   = pc[4:0];
    p.is_ZEROREG = 1'b0;
    return p;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic [31:0] pc2);
    bus.fu_valid     = v;
    bus.fu_packet[0] = mk(pc0);
    bus.fu_packet[1] = mk(pc1);
    bus.fu_packet[2] = mk(pc2);
  endtask

  task automatic test_reset;
    reset = 1'b1; squash = 1'b0; bus.cdb_ready = 1'b1;
    bus.fu_valid = 3'b000; bus.fu_packet = '0;
    #1;
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_src !== 2'd0 || bus.cdb_packet !== EX_PACKET_EMPTY) begin
      failures++; $display("FAIL reset_out: valid=%b src=%0d pkt=%h", bus.cdb_valid, bus.cdb_src, bus.cdb_packet);
    end
    @(negedge clock); reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if (bus.cdb_valid !== 1'b0 || bus.cdb_packet.is_ZEROREG !== 1'b1 || bus.fu_stall !== 3'b000) begin
        failures++; $display("FAIL idle[%0d]: valid=%b zr=%b stall=%b want 0 1 000", c, bus.cdb_valid, bus.cdb_packet.is_ZEROREG, bus.fu_stall);
      end
    end
  endtask

  task automatic test_all_three;
    logic [2:0] exp_stall [3] = '{3'b100, 3'b000, 3'b000};
    @(posedge clock); #1; drive(3'b111, 10, 11, 12);
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b000) begin failures++; $display("FAIL all3_accept: stall=%b want 000", bus.fu_stall); end
    @(posedge clock); #1; bus.fu_valid = 3'b000;
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b110 || bus.cdb_valid !== 1'b0) begin
      failures++; $display("FAIL all3_first: stall=%b valid=%b want 110 0", bus.fu_stall, bus.cdb_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'(k) || bus.cdb_packet !== mk(32'(10 + k)) || bus.fu_stall !== exp_stall[k]) begin
        failures++; $display("FAIL all3_seq[%0d]: valid=%b src=%0d pc=%0d stall=%b want 1 %0d %0d %b", k, bus.cdb_valid, bus.cdb_src, bus.cdb_packet.pc, bus.fu_stall, k, 10 + k, exp_stall[k]);
      end
    end
    @(negedge clock);
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_packet !== EX_PACKET_EMPTY) begin
      failures++; $display("FAIL all3_idle: valid=%b pkt=%h want 0 EMPTY", bus.cdb_valid, bus.cdb_packet);
    end
  endtask

  task automatic test_stream_fu1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clock); #1;
      drive((n < 6) ? 3'b010 : 3'b000, 0, 32'(100 + n), 0);
      @(negedge clock);
      checks++;
      if (bus.fu_stall !== 3'b000) begin failures++; $display("FAIL stream_stall[%0d]: stall=%b want 000", n, bus.fu_stall); end
      if (n >= 2) begin
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_packet.pc !== 32'(100 + n - 2)) begin
          failures++; $display("FAIL stream_out[%0d]: valid=%b src=%0d pc=%0d want 1 1 %0d", n, bus.cdb_valid, bus.cdb_src, bus.cdb_packet.pc, 100 + n - 2);
        end
      end
    end
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_backpressure;
    @(posedge clock); #1; drive(3'b101, 200, 0, 202); bus.cdb_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b000) begin failures++; $display("FAIL bp_accept: stall=%b want 000", bus.fu_stall); end
    @(posedge clock); #1; drive(3'b100, 0, 0, 212);
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b001) begin failures++; $display("FAIL bp_reload: stall=%b want 001", bus.fu_stall); end
    @(posedge clock); #1; bus.fu_valid = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2 || bus.cdb_packet !== mk(202) || bus.fu_stall !== 3'b101) begin
        failures++; $display("FAIL bp_hold[%0d]: valid=%b src=%0d pc=%0d stall=%b want 1 2 202 101", c, bus.cdb_valid, bus.cdb_src, bus.cdb_packet.pc, bus.fu_stall);
      end
    end
    @(posedge clock); #1; bus.cdb_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b100 || bus.cdb_packet.pc !== 32'd202) begin
      failures++; $display("FAIL bp_release: stall=%b pc=%0d want 100 202", bus.fu_stall, bus.cdb_packet.pc);
    end
    @(negedge clock);
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_packet.pc !== 32'd200 || bus.fu_stall !== 3'b000) begin
      failures++; $display("FAIL bp_drain0: valid=%b src=%0d pc=%0d stall=%b want 1 0 200 000", bus.cdb_valid, bus.cdb_src, bus.cdb_packet.pc, bus.fu_stall);
    end
    @(negedge clock);
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2 || bus.cdb_packet.pc !== 32'd212) begin
      failures++; $display("FAIL bp_drain1: valid=%b src=%0d pc=%0d want 1 2 212", bus.cdb_valid, bus.cdb_src, bus.cdb_packet.pc);
    end
    @(negedge clock);
    checks++;
    if (bus.cdb_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: valid=%b want 0", bus.cdb_valid); end
  endtask

  task automatic test_squash;
    @(posedge clock); #1; drive(3'b111, 300, 301, 302); bus.cdb_ready = 1'b0;
    @(posedge clock); #1; drive(3'b001, 310, 0, 0);
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b110) begin failures++; $display("FAIL sq_pre: stall=%b want 110", bus.fu_stall); end
    @(posedge clock); #1; drive(3'b111, 320, 321, 322); squash = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b000 || bus.cdb_valid !== 1'b1 || bus.cdb_packet.pc !== 32'd300) begin
      failures++; $display("FAIL sq_cycle: stall=%b valid=%b pc=%0d want 000 1 300", bus.fu_stall, bus.cdb_valid, bus.cdb_packet.pc);
    end
    @(posedge clock); #1; squash = 1'b0; bus.fu_valid = 3'b000; bus.cdb_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_packet !== EX_PACKET_EMPTY || bus.fu_stall !== 3'b000) begin
      failures++; $display("FAIL sq_after: valid=%b pkt=%h stall=%b want 0 EMPTY 000", bus.cdb_valid, bus.cdb_packet, bus.fu_stall);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
        failures++; $display("FAIL sq_leak[%0d]: valid=%b pc=%0d want 0", c, bus.cdb_valid, bus.cdb_packet.pc);
      end
    end
  endtask

  task automatic test_async_reset;
    @(posedge clock); #1; drive(3'b111, 400, 401, 402);
    @(posedge clock); #1; bus.fu_valid = 3'b000;
    @(posedge clock); #1;
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_packet.pc !== 32'd401) begin
      failures++; $display("FAIL ar_pre: valid=%b src=%0d pc=%0d want 1 1 401", bus.cdb_valid, bus.cdb_src, bus.cdb_packet.pc);
    end
    #1; reset = 1'b1;
    #1;
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_src !== 2'd0 || bus.cdb_packet !== EX_PACKET_EMPTY || bus.fu_stall !== 3'b000) begin
      failures++; $display("FAIL ar_async: valid=%b src=%0d pkt=%h stall=%b want 0 0 EMPTY 000", bus.cdb_valid, bus.cdb_src, bus.cdb_packet, bus.fu_stall);
    end
    #1; reset = 1'b0;
    @(posedge clock); #1; drive(3'b111, 500, 501, 502);
    @(posedge clock); #1; bus.fu_valid = 3'b000;
    @(negedge clock);
    checks++;
    if (bus.fu_stall !== 3'b110) begin failures++; $display("FAIL ar_ptr: stall=%b want 110", bus.fu_stall); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'(k) || bus.cdb_packet.pc !== 32'(500 + k)) begin
        failures++; $display("FAIL ar_seq[%0d]: valid=%b src=%0d pc=%0d want 1 %0d %0d", k, bus.cdb_valid, bus.cdb_src, bus.cdb_packet.pc, k, 500 + k);
      end
    end
  endtask

  initial begin
    test_reset;
    test_all_three;
    test_stream_fu1;
    test_backpressure;
    test_squash;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
